// File: rtl/reg_file_mp.sv
// Multi-ported register file with per-register busy scoreboard.
// Optional same-cycle write forwarding and hardwired-zero index 0.
module reg_file_mp #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 2,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_WR-1:0]              we,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rdata,
  input  logic                           alloc_valid,
  input  logic [ADDR_WIDTH-1:0]          alloc_addr,
  output logic [NUM_RD-1:0]              rbusy,
  output logic [(2**ADDR_WIDTH)-1:0]     busy_vec
);

  localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;

  // Writes clear first, allocation applied last so a new producer supersedes.
  always_comb begin
    busy_next = busy;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (we[k]) busy_next[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
    end
    if (alloc_valid) busy_next[alloc_addr] = 1'b1;
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
  end

  // Ascending port order means the higher-numbered port wins a same-index collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      busy <= busy_next;
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (we[k] && !((ZERO_REG != 0) && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == '0)))
          mem[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  logic [ADDR_WIDTH-1:0] ra;
  logic [DATA_WIDTH-1:0] rval;
  logic                  rbsy;

  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    rval  = '0;
    rbsy  = 1'b0;
    for (int unsigned j = 0; j < NUM_RD; j++) begin
      ra   = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
      rval = mem[ra];
      rbsy = busy[ra];
      if (BYPASS != 0) begin
        for (int unsigned k = 0; k < NUM_WR; k++) begin
          if (we[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
            rval = wdata[k*DATA_WIDTH +: DATA_WIDTH];
            rbsy = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) rval = '0;
      rdata[j*DATA_WIDTH +: DATA_WIDTH] = rval;
      rbusy[j] = rbsy;
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default build plus a no-bypass,
// ordinary-index-0 build driven by the same stimulus.
module tb_reg_file_mp;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   we;
  logic [9:0]   waddr;
  logic [127:0] wdata;
  logic [9:0]   raddr;
  logic         alloc_valid;
  logic [4:0]   alloc_addr;

  logic [127:0] rdata_a, rdata_b;
  logic [1:0]   rbusy_a, rbusy_b;
  logic [31:0]  busy_a, busy_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2),
                .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .rbusy(rbusy_a), .busy_vec(busy_a));

  reg_file_mp #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2),
                .BYPASS(0), .ZERO_REG(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .rbusy(rbusy_b), .busy_vec(busy_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 2'b00; waddr = '0; wdata = '0; alloc_valid = 1'b0; alloc_addr = '0;
  endtask

  initial begin
    rst = 1'b1; raddr = '0;
    idle();
    tick(); tick();
    rst = 1'b0;
    #1;

    // Post-reset: every index reads zero, no busy state
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(31 - i), 5'(i)};
      #1;
      chk($sformatf("rst_a_p0_%0d", i), rdata_a[63:0],   64'h0);
      chk($sformatf("rst_a_p1_%0d", i), rdata_a[127:64], 64'h0);
      chk($sformatf("rst_b_p0_%0d", i), rdata_b[63:0],   64'h0);
    end
    chk("rst_busy_a",  {32'h0, busy_a}, 64'h0);
    chk("rst_busy_b",  {32'h0, busy_b}, 64'h0);
    chk("rst_rbusy_a", {62'h0, rbusy_a}, 64'h0);
    chk("rst_rbusy_b", {62'h0, rbusy_b}, 64'h0);

    // Single write with same-cycle read
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {64'h0, 64'hDEAD}; raddr = {5'd0, 5'd3};
    #1;
    chk("byp_a_same", rdata_a[63:0], 64'hDEAD);
    chk("byp_b_same", rdata_b[63:0], 64'h0);
    tick(); idle(); #1;
    chk("byp_a_next", rdata_a[63:0], 64'hDEAD);
    chk("byp_b_next", rdata_b[63:0], 64'hDEAD);

    // Dual-port collision on index 7: port 1 wins
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {64'h22, 64'h11}; raddr = {5'd7, 5'd3};
    #1;
    chk("coll_a_same", rdata_a[127:64], 64'h22);
    chk("coll_b_same", rdata_b[127:64], 64'h0);
    tick(); idle(); #1;
    chk("coll_a_next", rdata_a[127:64], 64'h22);
    chk("coll_b_next", rdata_b[127:64], 64'h22);
    chk("coll_a_p0",   rdata_a[63:0],   64'hDEAD);

    // Write to index 0
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {64'h0, 64'hFF}; raddr = {5'd0, 5'd0};
    #1;
    chk("z_a_same", rdata_a[63:0], 64'h0);
    chk("z_b_same", rdata_b[63:0], 64'h0);
    tick(); idle(); #1;
    chk("z_a_next", rdata_a[63:0], 64'h0);
    chk("z_b_next", rdata_b[63:0], 64'hFF);
    chk("z_a_busy0", {63'h0, busy_a[0]}, 64'h0);

    // Allocate 5, then write it
    alloc_valid = 1'b1; alloc_addr = 5'd5; raddr = {5'd0, 5'd5};
    #1;
    chk("al_a_rbusy_comb", {63'h0, rbusy_a[0]}, 64'h0);
    chk("al_b_rbusy_comb", {63'h0, rbusy_b[0]}, 64'h0);
    tick(); idle();
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {64'h0, 64'h42};
    #1;
    chk("al_a_busy5",  {32'h0, busy_a}, 64'h20);
    chk("al_b_busy5",  {32'h0, busy_b}, 64'h20);
    chk("al_a_rbusy_wr", {63'h0, rbusy_a[0]}, 64'h0);
    chk("al_b_rbusy_wr", {63'h0, rbusy_b[0]}, 64'h1);
    chk("al_a_data_wr", rdata_a[63:0], 64'h42);
    tick(); idle(); #1;
    chk("al_a_cleared", {32'h0, busy_a}, 64'h0);
    chk("al_b_cleared", {32'h0, busy_b}, 64'h0);
    chk("al_a_rbusy_after", {63'h0, rbusy_a[0]}, 64'h0);
    chk("al_b_data_after", rdata_b[63:0], 64'h42);

    // Alloc and write 5 in the same cycle: allocation wins
    alloc_valid = 1'b1; alloc_addr = 5'd5;
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {64'h0, 64'h43};
    #1;
    chk("aw_a_rbusy_comb", {63'h0, rbusy_a[0]}, 64'h0);
    tick(); idle(); #1;
    chk("aw_a_busy", {32'h0, busy_a}, 64'h20);
    chk("aw_b_busy", {32'h0, busy_b}, 64'h20);
    chk("aw_a_rbusy", {63'h0, rbusy_a[0]}, 64'h1);
    chk("aw_b_rbusy", {63'h0, rbusy_b[0]}, 64'h1);
    chk("aw_a_data", rdata_a[63:0], 64'h43);

    // Allocation of index 0
    alloc_valid = 1'b1; alloc_addr = 5'd0; raddr = {5'd5, 5'd0};
    tick(); idle(); #1;
    chk("a0_a_busy", {32'h0, busy_a}, 64'h20);
    chk("a0_b_busy", {32'h0, busy_b}, 64'h21);
    chk("a0_a_rbusy", {62'h0, rbusy_a}, 64'h2);
    chk("a0_b_rbusy", {62'h0, rbusy_b}, 64'h3);

    // Alloc 9 + write 9 via port 1, then reset with traffic pending
    alloc_valid = 1'b1; alloc_addr = 5'd9;
    we = 2'b10; waddr = {5'd9, 5'd0}; wdata = {64'h5, 64'h0}; raddr = {5'd9, 5'd0};
    tick(); idle(); #1;
    chk("pre_a_busy", {32'h0, busy_a}, 64'h220);
    chk("pre_b_busy", {32'h0, busy_b}, 64'h221);
    chk("pre_a_d9", rdata_a[127:64], 64'h5);
    rst = 1'b1;
    we = 2'b01; waddr = {5'd0, 5'd12}; wdata = {64'h0, 64'h77};
    alloc_valid = 1'b1; alloc_addr = 5'd10;
    tick();
    rst = 1'b0; idle(); #1;
    chk("post_a_busy", {32'h0, busy_a}, 64'h0);
    chk("post_b_busy", {32'h0, busy_b}, 64'h0);
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(i), 5'(i)};
      #1;
      chk($sformatf("post_a_%0d", i), rdata_a[63:0],   64'h0);
      chk($sformatf("post_b_%0d", i), rdata_b[127:64], 64'h0);
    end
    tick(); #1;
    chk("post2_a_busy", {32'h0, busy_a}, 64'h0);
    chk("post2_b_busy", {32'h0, busy_b}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
